hw_accel_frame_sequencer: RTL

Per-frame controller for the hardware-accelerator DMA datapath. It accepts a start request, raises the `hw_accel_dma_init_done` level that arms the wrapper's output DMA, and counts the DMA input and output beats until both frame totals are reached. It then reports completion and enforces a minimum low gap before the next frame. On abort or a stall watchdog it pulses a datapath reset; it also keeps sticky error flags and a frame counter for the CPU status registers.

---
 rtl/hw_accel_frame_sequencer_if.sv | 49 ++++
 rtl/hw_accel_frame_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_frame_sequencer_if.sv
// Control/status bundle between the accelerator wrapper and its frame sequencer.
// slave: the sequencer side; master: the wrapper/CPU side driving start, abort and beats.
interface hw_accel_frame_sequencer_if;
    logic        start;
    logic        abort;
    logic        in_beat;
    logic        out_beat;
    logic        init_done;
    logic        accel_rst;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_overrun;
    logic [15:0] frame_count;
    logic [31:0] in_count;
    logic [31:0] out_count;

    modport slave (
        input  start,
        input  abort,
        input  in_beat,
        input  out_beat,
        output init_done,
        output accel_rst,
        output busy,
        output done,
        output err_timeout,
        output err_overrun,
        output frame_count,
        output in_count,
        output out_count
    );

    modport master (
        output start,
        output abort,
        output in_beat,
        output out_beat,
        input  init_done,
        input  accel_rst,
        input  busy,
        input  done,
        input  err_timeout,
        input  err_overrun,
        input  frame_count,
        input  in_count,
        input  out_count
    );
endinterface

// File: rtl/hw_accel_frame_sequencer.sv
// Per-frame DMA sequencer: arms init_done, counts in/out beats, enforces an inter-frame gap.
// Define HW_ACCEL_SEQ_TIMEOUT_EN to build the RUN-state stall watchdog.
module hw_accel_frame_sequencer #(
    parameter int unsigned IN_WORDS_PER_FRAME  = 307200,
    parameter int unsigned OUT_WORDS_PER_FRAME = 9216,
    parameter int unsigned TIMEOUT_CYCLES      = 16777216,
    parameter int unsigned GAP_CYCLES          = 4,
    parameter int unsigned FLUSH_CYCLES        = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    hw_accel_frame_sequencer_if.slave seq_if
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StDone  = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StFlush = 3'd4;

    localparam int unsigned TimerMax = (GAP_CYCLES > FLUSH_CYCLES) ? GAP_CYCLES : FLUSH_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam logic [TimerW-1:0] GapLoad   = TimerW'(GAP_CYCLES - 1);
    localparam logic [TimerW-1:0] FlushLoad = TimerW'(FLUSH_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [31:0]       in_count_q, in_count_d;
    logic [31:0]       out_count_q, out_count_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              err_overrun_q, err_overrun_d;
    logic              init_done_q, init_done_d;
    logic              accel_rst_q, accel_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              any_beat;
    logic              complete;

`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT_CYCLES - 1);

    logic [StallW-1:0] stall_q, stall_d;
    logic              err_timeout_q, err_timeout_d;
    logic              expire;
`endif

    assign any_beat = seq_if.in_beat | seq_if.out_beat;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        in_count_d    = in_count_q;
        out_count_d   = out_count_q;
        frame_count_d = frame_count_q;
        err_overrun_d = err_overrun_q;
        complete      = 1'b0;
`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
        stall_d       = stall_q;
        err_timeout_d = err_timeout_q;
        expire        = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (seq_if.start && !seq_if.abort) begin
                    state_d       = StRun;
                    in_count_d    = '0;
                    out_count_d   = '0;
                    err_overrun_d = 1'b0;
`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
                    stall_d       = '0;
                    err_timeout_d = 1'b0;
`endif
                end
                // A stray beat is an error even in the cycle a frame is requested.
                if (any_beat) begin
                    err_overrun_d = 1'b1;
                end
            end

            StRun: begin
                if (seq_if.in_beat) begin
                    if (in_count_q < IN_WORDS_PER_FRAME) begin
                        in_count_d = in_count_q + 32'd1;
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                if (seq_if.out_beat) begin
                    if (out_count_q < OUT_WORDS_PER_FRAME) begin
                        out_count_d = out_count_q + 32'd1;
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                // Judge completion on the next counts so simultaneous final beats finish at once.
                complete = (in_count_d == IN_WORDS_PER_FRAME) &&
                           (out_count_d == OUT_WORDS_PER_FRAME);
`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
                if (any_beat) begin
                    stall_d = '0;
                end else if (stall_q == StallMax) begin
                    expire = 1'b1;
                end else begin
                    stall_d = stall_q + StallW'(1);
                end
`endif
                if (seq_if.abort) begin
                    state_d = StFlush;
                    timer_d = FlushLoad;
                end else if (complete) begin
                    state_d       = StDone;
                    frame_count_d = frame_count_q + 16'd1;
                end
`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
                else if (expire) begin
                    state_d       = StFlush;
                    timer_d       = FlushLoad;
                    err_timeout_d = 1'b1;
                end
`endif
            end

            StDone: begin
                if (any_beat) begin
                    err_overrun_d = 1'b1;
                end
                if (seq_if.abort) begin
                    state_d = StFlush;
                    timer_d = FlushLoad;
                end else begin
                    state_d = StGap;
                    timer_d = GapLoad;
                end
            end

            StGap: begin
                if (any_beat) begin
                    err_overrun_d = 1'b1;
                end
                if (seq_if.abort) begin
                    state_d = StFlush;
                    timer_d = FlushLoad;
                end else if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            StFlush: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered from the next state so they align with it.
        init_done_d = (state_d == StRun);
        accel_rst_d = (state_d == StFlush);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            in_count_q    <= '0;
            out_count_q   <= '0;
            frame_count_q <= '0;
            err_overrun_q <= 1'b0;
            init_done_q   <= 1'b0;
            accel_rst_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            in_count_q    <= in_count_d;
            out_count_q   <= out_count_d;
            frame_count_q <= frame_count_d;
            err_overrun_q <= err_overrun_d;
            init_done_q   <= init_done_d;
            accel_rst_q   <= accel_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign seq_if.err_timeout = err_timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout     = ^TIMEOUT_CYCLES;
    assign seq_if.err_timeout = 1'b0;
`endif

    assign seq_if.init_done   = init_done_q;
    assign seq_if.accel_rst   = accel_rst_q;
    assign seq_if.busy        = busy_q;
    assign seq_if.done        = done_q;
    assign seq_if.err_overrun = err_overrun_q;
    assign seq_if.frame_count = frame_count_q;
    assign seq_if.in_count    = in_count_q;
    assign seq_if.out_count   = out_count_q;

endmodule
